nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 17 +
 rtl/nibble_serial_adder_cla4_core.sv | 40 ++++
 rtl/nibble_serial_adder.sv | 158 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder and its CLA slice.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a nibble index, never zero so a single-nibble build still has a register.
    function automatic int idx_bits(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_core.sv
// Combinational 4-bit carry-lookahead slice. The carry-into-MSB output exists
// only when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
module cla4_core
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                c_msb_o
`endif
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W:0]   c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Every carry is a flat sum of generate/propagate products, so none waits on a lower carry.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign sum_o  = p ^ c[NIBBLE_W-1:0];
    assign cout_o = c[NIBBLE_W];

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    assign c_msb_o = c[NIBBLE_W-1];
`endif

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial unsigned adder: one 4-bit CLA step per cycle, valid/ready on both sides.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the out_ovf signed-overflow output.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
    input  logic                        in_cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
    output logic                        out_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                        out_ovf
`endif
);

    localparam int               W        = NIBBLE_W * NIBBLES;
    localparam int               IDX_W    = idx_bits(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                valid_q, valid_d;
    logic                last_nib;
    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
    logic                nib_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic                ovf_q, ovf_d;
    logic                nib_c_msb;
`endif

    assign last_nib = (idx_q == LAST_IDX);

    cla4_core u_cla (
        .a_i    (nib_a),
        .b_i    (nib_b),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ,
        .c_msb_o(nib_c_msb)
`endif
    );

    // NOTE: state and datapath registers are all on the async reset, so an abort leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (last_nib) state_d = DONE;
            DONE:    if (valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) && !rst;
        out_valid = valid_q;
        out_sum   = sum_q;
        out_cout  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        out_ovf   = ovf_q;
`endif
    end

    always_comb begin
        nib_a   = '0;
        nib_b   = '0;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end

        if (state_q == IDLE && in_valid) begin
            a_d     = in_a;
            b_d     = in_b;
            carry_d = in_cin;
            idx_d   = '0;
        end else if (state_q == ADD) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDX_W'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = nib_sum;
            end
            carry_d = nib_cout;
            if (last_nib) begin
                cout_d = nib_cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
                ovf_d  = nib_c_msb ^ nib_cout;
`endif
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Result registers settle for one DONE cycle before being presented.
        valid_d = (state_q == DONE) && (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) plus NIBBLES=1/8 instances for random sums.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid = 1'b0;
    logic         in_cin = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ready, out_valid, out_cout;
    logic [W-1:0] out_sum;
    logic         out_ovf;

    logic         v1 = 1'b0, v8 = 1'b0;
    logic [3:0]   a1 = '0, b1 = '0, s1;
    logic [31:0]  a8 = '0, b8 = '0, s8;
    logic         rdy1, ov1, co1, ovf1;
    logic         rdy8, ov8, co8, ovf8;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .out_ovf(out_ovf)
`endif
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1),
        .in_a(a1), .in_b(b1), .in_cin(in_cin), .out_valid(ov1),
        .out_ready(out_ready), .out_sum(s1), .out_cout(co1)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .out_ovf(ovf1)
`endif
    );

    nibble_serial_adder #(.NIBBLES(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .in_cin(in_cin), .out_valid(ov8),
        .out_ready(out_ready), .out_sum(s8), .out_cout(co8)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        , .out_ovf(ovf8)
`endif
    );

    // Offers one operand pair; returns 1 time unit after the accepting edge.
    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_sum !== 16'h0000) $display("FAIL reset_out_sum got %h want 0000", out_sum); else passes++;
        checks++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout got %b want 0", out_cout); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else passes++;
    endtask

    task automatic test_basic();
        drive_op(16'h1234, 16'h4321, 1'b0);
        // Operand changes after acceptance must not reach the result.
        in_a = 16'hFFFF; in_b = 16'hFFFF; in_cin = 1'b1;
        for (int k = 1; k <= N + 1; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (k == N + 1))
                $display("FAIL latency_cycle%0d out_valid got %b want %b", k, out_valid, (k == N + 1));
            else passes++;
        end
        checks++; if (out_sum !== 16'h5555) $display("FAIL basic_sum got %h want 5555", out_sum); else passes++;
        checks++; if (out_cout !== 1'b0) $display("FAIL basic_cout got %b want 0", out_cout); else passes++;
        consume();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_consumed_valid got %b want 0", out_valid); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL basic_back_idle got %b want 1", in_ready); else passes++;
    endtask

    task automatic test_carry_cases();
        bit ok;
        logic [W-1:0] av [3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
        logic [W-1:0] bv [3] = '{16'h0000, 16'hFFFF, 16'h8000};
        logic         cv [3] = '{1'b1, 1'b1, 1'b0};
        logic [W-1:0] sv [3] = '{16'h0000, 16'hFFFF, 16'h0000};
        logic         ov [3] = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            drive_op(av[i], bv[i], cv[i]);
            wait_valid(ok);
            checks++; if (!ok) $display("FAIL carry%0d_timeout out_valid got 0 want 1", i); else passes++;
            checks++; if (out_sum !== sv[i]) $display("FAIL carry%0d_sum got %h want %h", i, out_sum, sv[i]); else passes++;
            checks++; if (out_cout !== ov[i]) $display("FAIL carry%0d_cout got %b want %b", i, out_cout, ov[i]); else passes++;
            consume();
        end
    endtask

    task automatic test_hold();
        bit ok;
        drive_op(16'hABCD, 16'h1111, 1'b0);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL hold_timeout out_valid got 0 want 1"); else passes++;
        in_valid = 1'b1; in_a = 16'h0F0F; in_b = 16'h0101;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) $display("FAIL hold%0d_valid got %b want 1", k, out_valid); else passes++;
            checks++; if (out_sum !== 16'hBCDE) $display("FAIL hold%0d_sum got %h want bcde", k, out_sum); else passes++;
            checks++; if (out_cout !== 1'b0) $display("FAIL hold%0d_cout got %b want 0", k, out_cout); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL hold%0d_in_ready got %b want 0", k, in_ready); else passes++;
        end
        in_valid = 1'b0;
        consume();
        checks++; if (in_ready !== 1'b1) $display("FAIL hold_release_idle got %b want 1", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL hold_release_valid got %b want 0", out_valid); else passes++;
    endtask

    task automatic test_abort();
        bit ok;
        bit seen_valid = 1'b0;
        drive_op(16'h1111, 16'h2222, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", out_valid); else passes++;
        checks++; if (out_sum !== 16'h0000) $display("FAIL abort_sum got %h want 0000", out_sum); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL abort_in_ready_during_rst got %b want 0", in_ready); else passes++;
        #1 rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready_after got %b want 1", in_ready); else passes++;
        for (int k = 0; k < N + 3; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid = 1'b1;
        end
        checks++; if (seen_valid !== 1'b0) $display("FAIL abort_partial_result got %b want 0", seen_valid); else passes++;
        drive_op(16'h0001, 16'h0001, 1'b0);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL after_abort_timeout out_valid got 0 want 1"); else passes++;
        checks++; if (out_sum !== 16'h0002) $display("FAIL after_abort_sum got %h want 0002", out_sum); else passes++;
        checks++; if (out_cout !== 1'b0) $display("FAIL after_abort_cout got %b want 0", out_cout); else passes++;
        consume();
    endtask

    task automatic test_ovf();
        bit ok;
        drive_op(16'h7FFF, 16'h0001, 1'b0);
        wait_valid(ok);
        checks++; if (!ok) $display("FAIL ovf_timeout out_valid got 0 want 1"); else passes++;
        checks++; if (out_sum !== 16'h8000) $display("FAIL ovf_sum got %h want 8000", out_sum); else passes++;
        checks++; if (out_cout !== 1'b0) $display("FAIL ovf_cout got %b want 0", out_cout); else passes++;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        checks++; if (out_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", out_ovf); else passes++;
`endif
        consume();
    endtask

    task automatic test_random();
        logic [4:0]  e1;
        logic [16:0] e4;
        logic [32:0] e8;
        logic [2:0]  seen;
        out_ready = 1'b1;
        for (int it = 0; it < 150; it++) begin
            @(posedge clk); #1;
            a1 = 4'($urandom); b1 = 4'($urandom);
            in_a = 16'($urandom); in_b = 16'($urandom);
            a8 = $urandom; b8 = $urandom;
            in_cin = 1'($urandom);
            e1 = 5'(a1) + 5'(b1) + 5'(in_cin);
            e4 = 17'(in_a) + 17'(in_b) + 17'(in_cin);
            e8 = 33'(a8) + 33'(b8) + 33'(in_cin);
            v1 = 1'b1; in_valid = 1'b1; v8 = 1'b1;
            @(posedge clk); #1;
            v1 = 1'b0; in_valid = 1'b0; v8 = 1'b0;
            seen = 3'b000;
            for (int cyc = 0; cyc < 20 && seen != 3'b111; cyc++) begin
                @(posedge clk); #1;
                if (ov1 && !seen[0]) begin
                    seen[0] = 1'b1;
                    checks++; if ({co1, s1} !== e1) $display("FAIL rand_n1_%0d got %h want %h", it, {co1, s1}, e1); else passes++;
                end
                if (out_valid && !seen[1]) begin
                    seen[1] = 1'b1;
                    checks++; if ({out_cout, out_sum} !== e4) $display("FAIL rand_n4_%0d got %h want %h", it, {out_cout, out_sum}, e4); else passes++;
                end
                if (ov8 && !seen[2]) begin
                    seen[2] = 1'b1;
                    checks++; if ({co8, s8} !== e8) $display("FAIL rand_n8_%0d got %h want %h", it, {co8, s8}, e8); else passes++;
                end
            end
            if (seen != 3'b111) begin
                checks++;
                $display("FAIL rand_timeout_%0d seen %b want 111", it, seen);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry_cases();
        test_hold();
        test_abort();
        test_ovf();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
